// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl: bottom-up full-row detection and collapse sequencer for the board memory
module line_clear_ctrl #(
    parameter int MEM_WIDTH  = 10,
    parameter int MEM_HEIGHT = 20,
    parameter int ADDR_W     = $clog2(MEM_HEIGHT),
    parameter int CNT_W      = $clog2(MEM_HEIGHT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     lines,
    output logic [15:0]          total_lines,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_rd_en,
    input  logic [MEM_WIDTH-1:0] mem_rd_data,
    output logic                 mem_wr_en,
    output logic [MEM_WIDTH-1:0] mem_wr_data
);
    typedef enum logic [2:0] {IDLE, RD, CHK, SH_RD, SH_WR, CLR_TOP, DONE} state_t;

    localparam logic [ADDR_W-1:0] BOTTOM = ADDR_W'(MEM_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] r, k;
    logic              full;

    assign full = &mem_rd_data;

    // state register, asynchronously cleared to IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // next-state and memory port decode; port idles at zero without a strobe
    always_comb begin
        state_nxt   = state;
        busy        = state != IDLE;
        done        = 1'b0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        case (state)
            IDLE:    state_nxt = start ? RD : IDLE;
            RD: begin
                mem_rd_en = 1'b1;
                mem_addr  = r;
                state_nxt = CHK;
            end
            CHK:     state_nxt = full ? ((r != '0) ? SH_RD : CLR_TOP) : ((r != '0) ? RD : DONE);
            SH_RD: begin
                mem_rd_en = 1'b1;
                mem_addr  = k - ONE;
                state_nxt = SH_WR;
            end
            SH_WR: begin
                mem_wr_en   = 1'b1;
                mem_addr    = k;
                mem_wr_data = mem_rd_data;
                state_nxt   = (k == ONE) ? CLR_TOP : SH_RD;
            end
            CLR_TOP: begin
                mem_wr_en = 1'b1;
                state_nxt = RD;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // row/shift pointers and line counters; r stays put after a clear so the row is re-checked
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r           <= '0;
            k           <= '0;
            lines       <= '0;
            total_lines <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    r     <= BOTTOM;
                    lines <= '0;
                end
                CHK: if (full) begin
                    k           <= r;
                    lines       <= lines + CNT_W'(1);
                    total_lines <= (&total_lines) ? total_lines : total_lines + 16'd1;
                end else if (r != '0) begin
                    r <= r - ONE;
                end
                SH_WR: k <= k - ONE;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_line_clear_ctrl.sv
// tb_line_clear_ctrl: directed scoreboard bench for line_clear_ctrl with a 6-row board model
module tb_line_clear_ctrl;
    localparam int W  = 10;
    localparam int H  = 6;
    localparam int AW = $clog2(H);
    localparam int CW = $clog2(H + 1);

    typedef logic [H-1:0][W-1:0] board_t;
    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] wr;
        logic [31:0] lines;
        board_t      board;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, mem_rd_en, mem_wr_en;
    logic [CW-1:0] lines;
    logic [15:0]   total_lines;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_rd_data;
    logic [W-1:0]  mem_wr_data;

    board_t mem;
    board_t ld_val;
    logic   ld = 1'b0;

    int   n_pass = 0;
    int   n_tot = 0;
    int   exp_total = 0;
    int   meas_cyc, meas_wr;
    exp_t q[$];

    line_clear_ctrl #(.MEM_WIDTH(W), .MEM_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .lines(lines), .total_lines(total_lines), .mem_addr(mem_addr),
        .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data)
    );

    always #5 clk = ~clk;

    // board memory: bench preload, row write at the edge, registered read
    always @(posedge clk) begin
        if (ld) mem <= ld_val;
        else if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tot++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // behavioural reference: scan from the bottom, drop each full row, count spec latency
    function automatic exp_t model(input board_t b);
        exp_t e;
        board_t m = b;
        int r = H - 1;
        e.cyc = 1; e.wr = 0; e.lines = 0;
        forever begin
            if (&m[r]) begin
                e.cyc += 3 + 2 * r;
                e.wr  += r + 1;
                e.lines++;
                for (int i = r; i > 0; i--) m[i] = m[i-1];
                m[0] = '0;
            end else begin
                e.cyc += 2;
                if (r == 0) break;
                r--;
            end
        end
        e.board = m;
        return e;
    endfunction

    task automatic load(input board_t b);
        @(negedge clk);
        ld_val = b; ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_total = 0;
    endtask

    task automatic run(input string tag, input board_t b, input int extra_at);
        exp_t e;
        int   cyc, wr, nd;
        e = model(b);
        exp_total = (exp_total + int'(e.lines) > 65535) ? 65535 : exp_total + int'(e.lines);
        q.push_back(e);
        load(b);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; wr = 0;
        while (!done && cyc < 400) begin
            chk({tag, "_port_idle"}, {31'd0, (mem_rd_en && mem_wr_en) ||
                (!mem_rd_en && !mem_wr_en && mem_addr != '0) || (!mem_wr_en && mem_wr_data != '0)}, 0);
            chk({tag, "_busy"}, {31'd0, busy}, 1);
            if (mem_wr_en) wr++;
            start = (cyc == extra_at);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, {31'd0, done}, 1);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 1);
        e = q.pop_front();
        meas_cyc = cyc; meas_wr = wr;
        chk({tag, "_cycles"}, cyc, e.cyc);
        chk({tag, "_lines"}, {{(32-CW){1'b0}}, lines}, e.lines);
        chk({tag, "_total"}, {16'd0, total_lines}, exp_total);
        chk({tag, "_writes"}, wr, e.wr);
        nd = 1;
        repeat (6) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk({tag, "_single_done"}, nd, 1);
        chk({tag, "_idle_busy"}, {31'd0, busy}, 0);
        chk({tag, "_lines_held"}, {{(32-CW){1'b0}}, lines}, e.lines);
        for (int i = 0; i < H; i++) chk($sformatf("%s_row%0d", tag, i), {22'd0, mem[i]}, {22'd0, e.board[i]});
    endtask

    initial begin
        board_t b;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_rd_en", {31'd0, mem_rd_en}, 0);
        chk("rst_wr_en", {31'd0, mem_wr_en}, 0);
        chk("rst_addr", {{(32-AW){1'b0}}, mem_addr}, 0);
        chk("rst_wr_data", {22'd0, mem_wr_data}, 0);
        chk("rst_lines", {{(32-CW){1'b0}}, lines}, 0);
        chk("rst_total", {16'd0, total_lines}, 0);
        rst = 1'b1;

        b = '0;
        run("empty", b, -1);
        chk("empty_cyc13", meas_cyc, 13);
        chk("empty_nowr", meas_wr, 0);

        b = '0; b[5] = 10'h3FF; b[4] = 10'h001;
        run("bottom", b, -1);
        chk("bottom_6wr", meas_wr, 6);
        chk("bottom_row5", {22'd0, mem[5]}, 32'h001);

        b = '0; b[5] = 10'h3FF; b[4] = 10'h155; b[3] = 10'h3FF; b[2] = 10'h2AA;
        run("two", b, -1);
        chk("two_row4", {22'd0, mem[4]}, 32'h2AA);

        b = '0; b[0] = 10'h3FF; b[3] = 10'h3FE;
        run("top_only", b, -1);

        do_reset();
        b = '1;
        run("full1", b, -1);
        chk("full1_total6", {16'd0, total_lines}, 6);
        run("full2", b, -1);
        chk("full2_total12", {16'd0, total_lines}, 12);

        b = '0; b[5] = 10'h3FF; b[4] = 10'h001;
        run("restart", b, 3);

        load(b);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("shwr_wr_en", {31'd0, mem_wr_en}, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_done", {31'd0, done}, 0);
        chk("arst_wr_en", {31'd0, mem_wr_en}, 0);
        chk("arst_rd_en", {31'd0, mem_rd_en}, 0);
        chk("arst_addr", {{(32-AW){1'b0}}, mem_addr}, 0);
        chk("arst_wr_data", {22'd0, mem_wr_data}, 0);
        chk("arst_lines", {{(32-CW){1'b0}}, lines}, 0);
        chk("arst_total", {16'd0, total_lines}, 0);
        repeat (2) @(negedge clk);
        chk("arst_no_done", {31'd0, done}, 0);
        rst = 1'b1;
        exp_total = 0;

        b = '0; b[5] = 10'h3FF; b[4] = 10'h155; b[3] = 10'h3FF; b[2] = 10'h2AA;
        run("post_rst", b, -1);
        chk("post_rst_total2", {16'd0, total_lines}, 2);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
